// File: rtl/ddr3_mcb_ref_exec.sv
// Refresh executor: drains the scheduler, precharges open banks, issues REFRESH, then pulses c_ref.
// Define REF_STATS_EN to add the ref_done_cnt / prea_skip_cnt statistics outputs.
module ddr3_mcb_ref_exec #(
  parameter int unsigned CtRP  = 11,
  parameter int unsigned CtRFC = 208,
  parameter int unsigned TW    = 10
) (
  input  logic       ddr3_mcb_clk,
  input  logic       ddr3_mcb_rst,
  input  logic       i_ready,
  input  logic       ref_req,
  input  logic       ref_alert,
  input  logic       arb_idle,
  input  logic [7:0] bank_open,
  input  logic       ref_cmd_ack,
  output logic       ref_cmd_valid,
  output logic [1:0] ref_cmd,
  output logic       ref_busy,
  output logic       c_ready,
  output logic       c_ref
`ifdef REF_STATS_EN
  ,
  output logic [15:0] ref_done_cnt,
  output logic [15:0] prea_skip_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, DRAIN, PREA, WAIT_RP, REF, WAIT_RFC, DONE, GUARD
  } state_t;

  localparam logic [1:0]    CMD_NONE = 2'b00;
  localparam logic [1:0]    CMD_PREA = 2'b01;
  localparam logic [1:0]    CMD_REF  = 2'b10;
  localparam logic [TW-1:0] RP_LOAD  = TW'(CtRP - 1);
  localparam logic [TW-1:0] RFC_LOAD = TW'(CtRFC - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam bit            RP_ONE   = (CtRP == 1);
  localparam bit            RFC_ONE  = (CtRFC == 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, timer_dec;
  logic          valid_q, valid_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic          cref_q, cref_d;

  assign timer_dec = (timer_q != '0) ? timer_q - T_ONE : '0;

  always_ff @(posedge ddr3_mcb_clk) begin
    if (ddr3_mcb_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      valid_q <= 1'b0;
      cmd_q   <= CMD_NONE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      cref_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      cref_q  <= cref_d;
    end
  end

  // Outputs are registered from the next state, so a wait state exits when the
  // timer reaches 1; the timer lands on 0 as the following command appears.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    valid_d = valid_q;
    cmd_d   = cmd_q;
    if (!i_ready) begin
      state_d = IDLE;
      timer_d = '0;
      valid_d = 1'b0;
      cmd_d   = CMD_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_req) state_d = DRAIN;
        end
        DRAIN: begin
          if (arb_idle) begin
            valid_d = 1'b1;
            if (|bank_open) begin
              state_d = PREA;
              cmd_d   = CMD_PREA;
            end else begin
              state_d = REF;
              cmd_d   = CMD_REF;
            end
          end
        end
        PREA: begin
          if (ref_cmd_ack && valid_q) begin
            timer_d = RP_LOAD;
            if (RP_ONE) begin
              state_d = REF;
              cmd_d   = CMD_REF;
            end else begin
              state_d = WAIT_RP;
              valid_d = 1'b0;
              cmd_d   = CMD_NONE;
            end
          end
        end
        WAIT_RP: begin
          timer_d = timer_dec;
          if (timer_q <= T_ONE) begin
            state_d = REF;
            valid_d = 1'b1;
            cmd_d   = CMD_REF;
          end
        end
        REF: begin
          if (ref_cmd_ack && valid_q) begin
            timer_d = RFC_LOAD;
            valid_d = 1'b0;
            cmd_d   = CMD_NONE;
            state_d = RFC_ONE ? DONE : WAIT_RFC;
          end
        end
        WAIT_RFC: begin
          timer_d = timer_dec;
          if (timer_q <= T_ONE) state_d = DONE;
        end
        DONE:    state_d = GUARD;
        GUARD:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    ready_d = (state_d == IDLE) && i_ready;
    cref_d  = (state_d == DONE);
    case (state_d)
      IDLE:    busy_d = ref_alert && i_ready;
      GUARD:   busy_d = 1'b0;
      default: busy_d = 1'b1;
    endcase
  end

  assign ref_cmd_valid = valid_q;
  assign ref_cmd       = cmd_q;
  assign ref_busy      = busy_q;
  assign c_ready       = ready_q;
  assign c_ref         = cref_q;

`ifdef REF_STATS_EN
  logic [15:0] done_cnt_q, done_cnt_d;
  logic [15:0] skip_cnt_q, skip_cnt_d;
  logic        skip_path;

  assign skip_path = (state_q == DRAIN) && (state_d == REF);

  always_comb begin
    done_cnt_d = done_cnt_q;
    skip_cnt_d = skip_cnt_q;
    if (cref_q && (done_cnt_q != 16'hFFFF)) done_cnt_d = done_cnt_q + 16'd1;
    if (skip_path && (skip_cnt_q != 16'hFFFF)) skip_cnt_d = skip_cnt_q + 16'd1;
  end

  always_ff @(posedge ddr3_mcb_clk) begin
    if (ddr3_mcb_rst) begin
      done_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      done_cnt_q <= done_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign ref_done_cnt  = done_cnt_q;
  assign prea_skip_cnt = skip_cnt_q;
`endif

endmodule

// File: tb/tb_ddr3_mcb_ref_exec.sv
// Scoreboard bench for ddr3_mcb_ref_exec: command/c_ref events are predicted with
// their cycle numbers when stimulus (ref_req, acks) is driven and checked on arrival.
module tb_ddr3_mcb_ref_exec;
  localparam int CtRP  = 11;
  localparam int CtRFC = 208;

  logic       clk, rst, i_ready, ref_req, ref_alert, arb_idle, ref_cmd_ack;
  logic [7:0] bank_open;
  logic       ref_cmd_valid, ref_busy, c_ready, c_ref;
  logic [1:0] ref_cmd;
`ifdef REF_STATS_EN
  logic [15:0] ref_done_cnt, prea_skip_cnt;
`endif

  ddr3_mcb_ref_exec #(.CtRP(CtRP), .CtRFC(CtRFC), .TW(10)) dut (
    .ddr3_mcb_clk (clk),
    .ddr3_mcb_rst (rst),
    .i_ready      (i_ready),
    .ref_req      (ref_req),
    .ref_alert    (ref_alert),
    .arb_idle     (arb_idle),
    .bank_open    (bank_open),
    .ref_cmd_ack  (ref_cmd_ack),
    .ref_cmd_valid(ref_cmd_valid),
    .ref_cmd      (ref_cmd),
    .ref_busy     (ref_busy),
    .c_ready      (c_ready),
    .c_ref        (c_ref)
`ifdef REF_STATS_EN
    ,
    .ref_done_cnt (ref_done_cnt),
    .prea_skip_cnt(prea_skip_cnt)
`endif
  );

  // kind: 1 = PREA valid rises, 2 = REF valid rises, 3 = c_ref pulse
  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  prea_dly = 0;
  int  ref_dly = 0;
  int  model_done = 0;
  int  model_skip = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endfunction

  task automatic expect_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexp_ev", kind, 0);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cyc", cyc, e.cyc);
    end
  endtask

  // Monitor and ack responder: acks after the configured number of valid cycles
  // and predicts the next event from the ack cycle.
  initial begin
    int  vcnt;
    int  cur_dly;
    int  last_dly;
    int  cref_cyc;
    bit  prev_v;
    ref_cmd_ack = 1'b0;
    vcnt = 0;
    last_dly = 0;
    cref_cyc = -10;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      ref_cmd_ack = 1'b0;
      if (rst) begin
        prev_v = 1'b0;
        vcnt = 0;
      end else begin
        if (ref_cmd_valid) begin
          if (!prev_v) expect_ev(int'(ref_cmd));
          vcnt++;
          cur_dly = (ref_cmd == 2'b01) ? prea_dly : ref_dly;
          if (vcnt == cur_dly + 1) begin
            ref_cmd_ack = 1'b1;
            last_dly = cur_dly;
            if (ref_cmd == 2'b01) push_ev(2, cyc + CtRP);
            else push_ev(3, cyc + CtRFC);
          end
        end else if (prev_v) begin
          chk("valid_len", vcnt, last_dly + 1);
          vcnt = 0;
        end
        prev_v = ref_cmd_valid;
        if (c_ref) begin
          expect_ev(3);
          cref_cyc = cyc;
        end
        if (cyc == cref_cyc + 1) begin
          chk("cref_width", c_ref, 0);
          chk("guard_ready", c_ready, 0);
          chk("guard_busy", ref_busy, 0);
        end
        if (cyc == cref_cyc + 2) chk("ready_back", c_ready, 1);
      end
    end
  end

  task automatic start_ref(input logic [7:0] bo);
    bank_open = bo;
    ref_req = 1'b1;
    push_ev((bo != 8'h00) ? 1 : 2, cyc + 2);
    if (bo == 8'h00) model_skip++;
    @(negedge clk);
    ref_req = 1'b0;
  endtask

  task automatic wait_quiet(input int lim);
    int n = 0;
    while ((exp_q.size() != 0 || c_ready !== 1'b1) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("quiet_queue", exp_q.size(), 0);
    chk("quiet_ready", c_ready, 1);
  endtask

  initial begin
    int n;
    int b;
    rst = 1'b1;
    i_ready = 1'b1;
    ref_req = 1'b0;
    ref_alert = 1'b0;
    arb_idle = 1'b1;
    bank_open = 8'h00;

    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", {ref_cmd_valid, ref_cmd, ref_busy, c_ready, c_ref}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", c_ready, 1);
    chk("busy_after_rst", ref_busy, 0);

    // Open banks, immediate acks; ref_alert raises busy early
    bank_open = 8'h05;
    ref_alert = 1'b1;
    @(negedge clk);
    chk("alert_busy", ref_busy, 1);
    chk("alert_ready", c_ready, 1);
    start_ref(8'h05);
    ref_alert = 1'b0;
    chk("drain_ready", c_ready, 0);
    chk("drain_busy", ref_busy, 1);
    wait_quiet(400);
    model_done++;

    // No open banks, arbiter busy for 20 cycles: REF directly after drain
    bank_open = 8'h00;
    arb_idle = 1'b0;
    ref_req = 1'b1;
    @(negedge clk);
    ref_req = 1'b0;
    repeat (19) begin
      chk("drain_hold_busy", ref_busy, 1);
      chk("drain_hold_valid", ref_cmd_valid, 0);
      @(negedge clk);
    end
    arb_idle = 1'b1;
    push_ev(2, cyc + 1);
    model_skip++;
    @(negedge clk);
    bank_open = 8'hFF;
    wait_quiet(400);
    model_done++;

    // PREA ack delayed 5 cycles
    prea_dly = 5;
    start_ref(8'h80);
    wait_quiet(400);
    prea_dly = 0;
    model_done++;

    // i_ready drop in the middle of tRFC
    start_ref(8'h01);
    n = 0;
    while (!(exp_q.size() > 0 && exp_q[0].kind == 3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_armed", exp_q.size(), 1);
    b = (exp_q.size() > 0) ? exp_q[0].cyc - CtRFC : cyc;
    while (cyc < b + 50) @(negedge clk);
    i_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_outs", {ref_cmd_valid, ref_cmd, ref_busy, c_ready, c_ref}, 0);
    repeat (10) begin
      @(negedge clk);
      chk("abort_ready_low", c_ready, 0);
    end
    i_ready = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", c_ready, 1);
    repeat (CtRFC) @(negedge clk);
    chk("abort_no_events", exp_q.size(), 0);

    // Stale request during GUARD must not start another refresh
    start_ref(8'h00);
    n = 0;
    while (c_ref !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("stale_cref_seen", c_ref, 1);
    @(negedge clk);
    ref_req = 1'b1;
    @(negedge clk);
    ref_req = 1'b0;
    repeat (10) @(negedge clk);
    model_done++;
    chk("stale_queue", exp_q.size(), 0);
    chk("stale_valid", ref_cmd_valid, 0);
    chk("stale_busy", ref_busy, 0);

`ifdef REF_STATS_EN
    chk("done_cnt", ref_done_cnt, model_done);
    chk("skip_cnt", prea_skip_cnt, model_skip);
`endif

    chk("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
